adc128s_fc_model: RTL and testbench

// - Behavioural SPI-slave model of an 8-channel, 12-bit ADC128S A2D for the Segway top-level bench.
// - Channels are hard-wired to bench stimulus: left and right load cells, steering pot and battery.
// - Answers the DUT's A2D interface: the frame N command selects the channel returned in frame N+1.

---
 rtl/adc128s_pkg.sv | 8 +
 rtl/spi_sync_edge.sv | 27 ++
 rtl/adc128s_fc_model.sv | 72 +++++++
 tb/tb_adc128s_fc_model.sv | 120 ++++++++++++
 4 files changed

// File: rtl/adc128s_pkg.sv
// adc128s_pkg: channel map and state type shared by the ADC128S SPI-slave model
package adc128s_pkg;
   localparam logic [2:0] CH_LD_LFT  = 3'd0;
   localparam logic [2:0] CH_LD_RGHT = 3'd4;
   localparam logic [2:0] CH_STEER   = 3'd5;
   localparam logic [2:0] CH_BATT    = 3'd6;
   typedef enum logic {IDLE, XFER} adc_state_t;
endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge: double-flop synchroniser plus history flop with registered edge pulses
// Ports: clk, rst_n (async active-low), din (async input, idles high),
//        sync (synchronised level), rise/fall (one-clk registered edge pulses)
module spi_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic sync,
   output logic rise,
   output logic fall
);
   logic ff1, ff2, ff3;
   // Flops reset high because both SCLK and SS_n idle high
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         {ff1, ff2, ff3} <= 3'b111;
         rise <= 1'b0;
         fall <= 1'b0;
      end else begin
         ff1 <= din;
         ff2 <= ff1;
         ff3 <= ff2;
         rise <= ff2 & ~ff3;
         fall <= ~ff2 & ff3;
      end
   assign sync = ff2;
endmodule

// File: rtl/adc128s_fc_model.sv
// adc128s_fc_model: SPI-slave model of an 8-channel 12-bit ADC128S; frame N command picks frame N+1 result
// Ports: clk, rst_n (async active-low), SS_n/SCLK/MOSI (SPI from master), MISO (result, high-Z when deselected),
//        ld_cell_lft (ch0), ld_cell_rght (ch4), steerPot (ch5), batt (ch6)
module adc128s_fc_model
   import adc128s_pkg::*;
(
   input  logic        clk,
   input  logic        rst_n,
   input  logic        SS_n,
   input  logic        SCLK,
   input  logic        MOSI,
   output logic        MISO,
   input  logic [11:0] ld_cell_lft,
   input  logic [11:0] ld_cell_rght,
   input  logic [11:0] steerPot,
   input  logic [11:0] batt
);
   adc_state_t state, nxt_state;
   logic        ss_sync, ss_rise, ss_fall, sclk_sync_unused, sclk_rise, sclk_fall;
   logic [2:0]  chnl_ptr;
   logic [15:0] rx_shft, tx_shft;
   logic [4:0]  bit_cnt;
   logic        seen_rise;
   logic [11:0] chnl_val;
   logic        cmd_unused;

   spi_sync_edge u_sclk (.clk(clk), .rst_n(rst_n), .din(SCLK), .sync(sclk_sync_unused), .rise(sclk_rise), .fall(sclk_fall));
   spi_sync_edge u_ss   (.clk(clk), .rst_n(rst_n), .din(SS_n), .sync(ss_sync), .rise(ss_rise), .fall(ss_fall));

   always_comb
      chnl_val = (chnl_ptr == CH_LD_LFT)  ? ld_cell_lft  :
                 (chnl_ptr == CH_LD_RGHT) ? ld_cell_rght :
                 (chnl_ptr == CH_STEER)   ? steerPot     :
                 (chnl_ptr == CH_BATT)    ? batt         : 12'h000;

   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) state <= IDLE;
      else        state <= nxt_state;

   always_comb begin
      nxt_state = state;
      if (state == IDLE && ss_fall) nxt_state = XFER;
      if (state == XFER && ss_rise) nxt_state = IDLE;
   end

   // Analog inputs are sampled only at frame start so mid-frame changes cannot corrupt the word in flight
   always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
         chnl_ptr  <= 3'd0;
         rx_shft   <= 16'h0000;
         tx_shft   <= 16'h0000;
         bit_cnt   <= 5'd0;
         seen_rise <= 1'b0;
      end else if (ss_fall) begin
         tx_shft   <= {4'h0, chnl_val};
         bit_cnt   <= 5'd0;
         seen_rise <= 1'b0;
      end else if (state == XFER) begin
         if (sclk_rise) begin
            rx_shft   <= {rx_shft[14:0], MOSI};
            bit_cnt   <= (bit_cnt == 5'd16) ? bit_cnt : bit_cnt + 5'd1;
            seen_rise <= 1'b1;
         end
         // A leading fall before the first rise must not shift, keeping the MSB valid at rise 1
         if (sclk_fall && seen_rise) tx_shft <= {tx_shft[14:0], 1'b0};
         // Only complete 16-bit frames update the channel for the next frame
         if (ss_rise && bit_cnt == 5'd16) chnl_ptr <= rx_shft[13:11];
      end

   assign cmd_unused = ^{rx_shft[15:14], rx_shft[10:0]};
   assign MISO = ss_sync ? 1'bz : tx_shft[15];
endmodule

// File: tb/tb_adc128s_fc_model.sv
// tb_adc128s_fc_model: table-driven frame checks plus abort, mid-frame change and mid-frame reset sequences
module tb_adc128s_fc_model;
   localparam int HP = 160;
   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        SS_n = 1'b1;
   logic        SCLK = 1'b1;
   logic        MOSI = 1'b0;
   wire         MISO;
   logic [11:0] ld_cell_lft = '0, ld_cell_rght = '0, steerPot = '0, batt = '0;
   int          n_cmp = 0, n_err = 0;

   // Deselected MISO floats; the pull-up makes high-Z observable as 1
   pullup (MISO);

   adc128s_fc_model dut (
      .clk(clk), .rst_n(rst_n), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
      .ld_cell_lft(ld_cell_lft), .ld_cell_rght(ld_cell_rght), .steerPot(steerPot), .batt(batt)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [15:0] cmd;
      logic [11:0] lft, rght, steer, bat;
      logic [15:0] exp;
   } vec_t;
   vec_t vecs[12];

   task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Master drives MOSI on SCLK fall and samples MISO just before SCLK rise
   task automatic frame(input logic [15:0] cmd, input int nbits, input bit raise_ss, output logic [15:0] got);
      got = '0;
      SS_n = 1'b0;
      #HP;
      for (int i = 0; i < nbits; i++) begin
         SCLK = 1'b0;
         MOSI = cmd[15-i];
         #HP;
         got[15-i] = MISO;
         SCLK = 1'b1;
         #HP;
      end
      if (raise_ss) begin
         SS_n = 1'b1;
         #HP;
      end
   endtask

   logic [15:0] w;

   initial begin
      vecs[0]  = '{16'h0000, 12'h14A, 12'h000, 12'h000, 12'h000, 16'h014A};
      vecs[1]  = '{16'h2800, 12'h14A, 12'h000, 12'h800, 12'h000, 16'h014A};
      vecs[2]  = '{16'h0000, 12'h14A, 12'h000, 12'h800, 12'h000, 16'h0800};
      vecs[3]  = '{16'h2000, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0123};
      vecs[4]  = '{16'h3000, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h014A};
      vecs[5]  = '{16'h0000, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0FFF};
      vecs[6]  = '{16'h0800, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0123};
      vecs[7]  = '{16'h1000, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0000};
      vecs[8]  = '{16'h1800, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0000};
      vecs[9]  = '{16'h3800, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0000};
      vecs[10] = '{16'hEFFF, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0000};
      vecs[11] = '{16'h0000, 12'h123, 12'h14A, 12'h800, 12'hFFF, 16'h0800};

      repeat (3) @(negedge clk);
      rst_n = 1'b1;
      repeat (3) @(negedge clk);
      check("reset_miso_hiz", {15'd0, MISO}, 16'h0001);

      for (int k = 0; k < 12; k++) begin
         ld_cell_lft = vecs[k].lft; ld_cell_rght = vecs[k].rght;
         steerPot = vecs[k].steer; batt = vecs[k].bat;
         frame(vecs[k].cmd, 16, 1'b1, w);
         check($sformatf("frame%0d_cmd%h", k, vecs[k].cmd), w, vecs[k].exp);
         check($sformatf("frame%0d_idle_hiz", k), {15'd0, MISO}, 16'h0001);
      end

      // Mid-frame input change: word in flight keeps the value sampled at SS fall
      ld_cell_lft = 12'h5A5;
      fork
         frame(16'h0000, 16, 1'b1, w);
         begin #(HP*9); ld_cell_lft = 12'hFFF; end
      join
      check("midframe_change", w, 16'h05A5);

      // Aborted frame leaves the channel pointer at ch5
      steerPot = 12'h456;
      frame(16'h2800, 16, 1'b1, w);
      check("pre_abort", w, 16'h0FFF);
      frame(16'h3000, 8, 1'b1, w);
      frame(16'h0000, 16, 1'b1, w);
      check("after_abort", w, 16'h0456);

      // Mid-frame reset after a ch5 command returns to channel 0
      ld_cell_lft = 12'h321;
      frame(16'h2800, 16, 1'b1, w);
      check("pre_reset", w, 16'h0321);
      frame(16'h0000, 8, 1'b0, w);
      rst_n = 1'b0;
      #HP;
      rst_n = 1'b1;
      #HP;
      SS_n = 1'b1;
      #HP;
      check("post_reset_hiz", {15'd0, MISO}, 16'h0001);
      frame(16'h0000, 16, 1'b1, w);
      check("after_reset", w, 16'h0321);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
